// File: rtl/switch_debounce_sync.sv
// Switch/button conditioner: per-channel synchroniser chain followed by a
// stability-counter debouncer that produces clean levels and one-cycle
// rise/fall strobes.
// Optional build macro SWITCH_DEBOUNCE_BYPASS_EN: drops the debouncer and
// registers the synchronised level once (fast bring-up / simulation).
`timescale 1ns/1ps

module switch_debounce_sync #(
    parameter int unsigned NUM_INPUTS      = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] raw_in,
    output logic [NUM_INPUTS-1:0] clean_out,
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse
);

    logic [NUM_INPUTS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_INPUTS-1:0] sync;

    // Synchroniser chains, one bit per channel in each stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef SWITCH_DEBOUNCE_BYPASS_EN

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
        logic clean_q, rise_q, fall_q;

        // Single register stage; strobes come from the edge of that level.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                clean_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                clean_q <= sync[i];
                rise_q  <= sync[i] & ~clean_q;
                fall_q  <= ~sync[i] & clean_q;
            end
        end

        assign clean_out[i]  = clean_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
    end

`else

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The change commits on the edge registering the D-th mismatch, i.e. when
    // the count of mismatches already seen equals D-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StStable, StSettling} state_e;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             clean_q, clean_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        // Next-state: count consecutive mismatches, commit on the last one.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            clean_d = clean_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            unique case (state_q)
                StStable: begin
                    cnt_d = '0;
                    if (sync[i] != clean_q) begin
                        if (CNT_LAST == '0) begin
                            clean_d = sync[i];
                            rise_d  = sync[i];
                            fall_d  = ~sync[i];
                        end else begin
                            state_d = StSettling;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                StSettling: begin
                    if (sync[i] == clean_q) begin
                        // Bounce: abandon the settle without touching the output.
                        state_d = StStable;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = StStable;
                        cnt_d   = '0;
                        clean_d = sync[i];
                        rise_d  = sync[i];
                        fall_d  = ~sync[i];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end

        // Channel state register.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q <= StStable;
                cnt_q   <= '0;
                clean_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                clean_q <= clean_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign clean_out[i]  = clean_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
    end

`endif

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Scoreboard bench for switch_debounce_sync: stimulus pushes the expected
// output events, a monitor pops and compares whenever a strobe appears.
`timescale 1ns/1ps

module tb_switch_debounce_sync;

    localparam int unsigned NI = 2;
    localparam int unsigned DC = 8;
    localparam int unsigned SS = 2;
`ifdef SWITCH_DEBOUNCE_BYPASS_EN
    localparam int LAT = SS;
`else
    localparam int LAT = SS + DC - 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NI-1:0] raw_in = '0;
    logic [NI-1:0] clean_out;
    logic [NI-1:0] rise_pulse;
    logic [NI-1:0] fall_pulse;

    switch_debounce_sync #(
        .NUM_INPUTS     (NI),
        .DEBOUNCE_CYCLES(DC),
        .SYNC_STAGES    (SS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clock = ~clock;

    // Edge counter: edge 1 is the first rising edge after the initial release.
    int cyc = 0;
    bit counting = 1'b0;
    always @(posedge clock) if (counting) cyc <= cyc + 1;

    typedef struct {
        int        when_e;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    bit monitor_on = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int e, input logic [1:0] c, input logic [1:0] r,
                             input logic [1:0] f);
        exp_t x;
        x.when_e = e + LAT;
        x.clean  = c;
        x.rise   = r;
        x.fall   = f;
        exp_q.push_back(x);
    endtask

    // Return at the falling edge following rising edge n.
    task automatic wait_edge(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    // Apply v so that it is set up before rising edge e.
    task automatic set_before(input int e, input logic [1:0] v);
        wait_edge(e - 1);
        raw_in = v;
    endtask

    // Monitor: any strobe must match the head of the expected queue.
    always @(negedge clock) begin
        if (monitor_on && (rise_pulse != '0 || fall_pulse != '0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got rise=%b fall=%b, required none (edge %0d)",
                         rise_pulse, fall_pulse, cyc);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("ev_edge", cyc, x.when_e);
                check("ev_clean", int'(clean_out), int'(x.clean));
                check("ev_rise", int'(rise_pulse), int'(x.rise));
                check("ev_fall", int'(fall_pulse), int'(x.fall));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_clean", int'(clean_out), 0);
        check("rst_rise", int'(rise_pulse), 0);
        check("rst_fall", int'(fall_pulse), 0);
        reset      = 1'b0;
        counting   = 1'b1;
        monitor_on = 1'b1;

`ifdef SWITCH_DEBOUNCE_BYPASS_EN
        // Both channels together: change 3 edges after the input.
        set_before(10, 2'b11);
        expect_ev(10, 2'b11, 2'b11, 2'b00);
        wait_edge(11);
        check("byp_before_rise", int'(clean_out), 0);
        wait_edge(12);
        check("byp_after_rise", int'(clean_out), 3);
        set_before(20, 2'b00);
        expect_ev(20, 2'b00, 2'b00, 2'b11);
        wait_edge(30);
`else
        // Clean step on channel 0: rise at edge 19.
        set_before(10, 2'b01);
        expect_ev(10, 2'b01, 2'b01, 2'b00);
        wait_edge(18);
        check("step_before", int'(clean_out), 0);
        wait_edge(19);
        check("step_after", int'(clean_out), 1);

        // Bounce on channel 1: high 5, low 2, high 3, low; never reaches the output.
        set_before(25, 2'b11);
        set_before(30, 2'b01);
        set_before(32, 2'b11);
        set_before(35, 2'b01);
        wait_edge(45);
        check("bounce_reject", int'(clean_out), 1);

        // Falling edge on channel 0: fall at edge 59.
        set_before(50, 2'b00);
        expect_ev(50, 2'b00, 2'b00, 2'b01);
        wait_edge(58);
        check("fall_before", int'(clean_out), 1);
        wait_edge(59);
        check("fall_after", int'(clean_out), 0);

        // Toggle every 3 cycles, then hold high: rise 9 edges after the last toggle.
        set_before(70, 2'b01);
        set_before(73, 2'b00);
        set_before(76, 2'b01);
        set_before(79, 2'b00);
        set_before(82, 2'b01);
        expect_ev(82, 2'b01, 2'b01, 2'b00);
        wait_edge(90);
        check("settle_before", int'(clean_out), 0);
        wait_edge(91);
        check("settle_after", int'(clean_out), 1);

        // Reset while channel 0 is settling towards 0: no fall strobe, outputs clear at once.
        set_before(100, 2'b00);
        wait_edge(104);
        reset = 1'b1;
        #1;
        check("rst_async_clean", int'(clean_out), 0);
        check("rst_async_rise", int'(rise_pulse), 0);
        check("rst_async_fall", int'(fall_pulse), 0);
        raw_in = 2'b11;
        wait_edge(107);
        reset = 1'b0;
        // Both channels high through release: rise together 10 edges later.
        expect_ev(108, 2'b11, 2'b11, 2'b00);
        wait_edge(116);
        check("post_rst_before", int'(clean_out), 0);
        wait_edge(117);
        check("post_rst_after", int'(clean_out), 3);

        // Both channels fall together.
        set_before(130, 2'b00);
        expect_ev(130, 2'b00, 2'b00, 2'b11);
        wait_edge(150);
`endif
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
